cpu_controller: RTL and testbench

Instruction-sequencing state machine for the lab7_top SimpleRISC CPU. It sits between the instruction register/decoder and the datapath, register file and RAM. Each instruction runs through fetch (IF1, IF2, UPDATE_PC, DECODE) and then a per-class execute sequence. On every cycle it drives every datapath, PC, IR and memory-command control.

---
 rtl/cpu_pkg.sv | 98 +++++++++
 rtl/cpu_controller_classify.sv | 26 ++
 rtl/cpu_controller.sv | 137 +++++++++++++
 tb/tb_cpu_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the SimpleRISC instruction-sequencing controller.
package cpu_pkg;

   typedef enum logic [4:0] {
      S_RST, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE, S_DECODE_NOP,
      S_WR_IMM, S_GET_A, S_GET_B, S_ALU_C0, S_ALU_C1, S_CMP_S, S_WR_RD,
      S_ADDR_C, S_LD_ADDR, S_MEM_RD, S_MEM_WB, S_GET_D, S_STR_C, S_MEM_WR,
      S_HALT, S_TRAP
   } state_t;

   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   localparam logic [2:0] NSEL_NONE = 3'b000;
   localparam logic [2:0] NSEL_RN   = 3'b001;
   localparam logic [2:0] NSEL_RD   = 3'b010;
   localparam logic [2:0] NSEL_RM   = 3'b100;

   localparam logic [1:0] VSEL_C     = 2'b00;
   localparam logic [1:0] VSEL_PC8   = 2'b01;
   localparam logic [1:0] VSEL_IMM   = 2'b10;
   localparam logic [1:0] VSEL_MDATA = 2'b11;

   localparam logic [2:0] OPC_LDR  = 3'b011;
   localparam logic [2:0] OPC_STR  = 3'b100;
   localparam logic [2:0] OPC_ALU  = 3'b101;
   localparam logic [2:0] OPC_MOV  = 3'b110;
   localparam logic [2:0] OPC_HALT = 3'b111;

   localparam logic [1:0] OP_MOVR = 2'b00;
   localparam logic [1:0] OP_MOVI = 2'b10;
   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_CMP  = 2'b01;
   localparam logic [1:0] OP_AND  = 2'b10;
   localparam logic [1:0] OP_MVN  = 2'b11;
   localparam logic [1:0] OP_MEM  = 2'b00;
   localparam logic [1:0] OP_HALT = 2'b00;

   typedef enum logic [3:0] {
      C_MOVI, C_MOVR, C_ALU, C_CMP, C_MVN, C_LDR, C_STR, C_HALT, C_ILLEGAL
   } cls_t;

   typedef struct packed {
      logic       load_pc;
      logic       reset_pc;
      logic       addr_sel;
      logic       load_ir;
      logic       load_addr;
      logic [1:0] mem_cmd;
      logic [2:0] nsel;
      logic [1:0] vsel;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       bsel;
      logic       write;
      logic       retire;
      logic       halted;
   } ctrl_t;

   // Moore output table: every control as a pure function of the state.
   function automatic ctrl_t ctrl_decode(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_RST:        begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
         S_IF1:        begin c.addr_sel = 1'b1; c.mem_cmd = MREAD; end
         S_IF2:        begin c.addr_sel = 1'b1; c.mem_cmd = MREAD; c.load_ir = 1'b1; end
         S_UPDATE_PC:  c.load_pc = 1'b1;
         S_DECODE_NOP: c.retire = 1'b1;
         S_WR_IMM:     begin c.nsel = NSEL_RN; c.vsel = VSEL_IMM; c.write = 1'b1; c.retire = 1'b1; end
         S_GET_A:      begin c.nsel = NSEL_RN; c.loada = 1'b1; end
         S_GET_B:      begin c.nsel = NSEL_RM; c.loadb = 1'b1; end
         S_ALU_C0:     c.loadc = 1'b1;
         S_ALU_C1:     begin c.loadc = 1'b1; c.asel = 1'b1; end
         S_CMP_S:      begin c.loads = 1'b1; c.retire = 1'b1; end
         S_WR_RD:      begin c.nsel = NSEL_RD; c.vsel = VSEL_C; c.write = 1'b1; c.retire = 1'b1; end
         S_ADDR_C:     begin c.bsel = 1'b1; c.loadc = 1'b1; end
         S_LD_ADDR:    c.load_addr = 1'b1;
         S_MEM_RD:     c.mem_cmd = MREAD;
         S_MEM_WB:     begin
            c.mem_cmd = MREAD; c.nsel = NSEL_RD; c.vsel = VSEL_MDATA;
            c.write = 1'b1; c.retire = 1'b1;
         end
         S_GET_D:      begin c.nsel = NSEL_RD; c.loadb = 1'b1; end
         S_STR_C:      begin c.asel = 1'b1; c.loadc = 1'b1; end
         S_MEM_WR:     begin c.mem_cmd = MWRITE; c.retire = 1'b1; end
         S_HALT,
         S_TRAP:       c.halted = 1'b1;
         default:      c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cpu_controller_classify.sv
// Maps the IR opcode/op fields to an instruction class.
module cpu_controller_classify
   import cpu_pkg::*;
(
   input  logic [2:0] i_opcode,
   input  logic [1:0] i_op,
   output cls_t       o_cls
);

   always_comb begin
      o_cls = C_ILLEGAL;
      case ({i_opcode, i_op})
         {OPC_MOV,  OP_MOVI}: o_cls = C_MOVI;
         {OPC_MOV,  OP_MOVR}: o_cls = C_MOVR;
         {OPC_ALU,  OP_MVN }: o_cls = C_MVN;
         {OPC_ALU,  OP_ADD },
         {OPC_ALU,  OP_AND }: o_cls = C_ALU;
         {OPC_ALU,  OP_CMP }: o_cls = C_CMP;
         {OPC_LDR,  OP_MEM }: o_cls = C_LDR;
         {OPC_STR,  OP_MEM }: o_cls = C_STR;
         {OPC_HALT, OP_HALT}: o_cls = C_HALT;
         default:             o_cls = C_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/cpu_controller.sv
// SimpleRISC instruction-sequencing FSM with registered Moore outputs.
// Optional CPU_CONTROLLER_TRAP_EN: undefined encodings trap instead of executing as NOPs.
module cpu_controller
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   output logic       load_pc,
   output logic       reset_pc,
   output logic       addr_sel,
   output logic       load_ir,
   output logic       load_addr,
   output logic [1:0] mem_cmd,
   output logic [2:0] nsel,
   output logic [1:0] vsel,
   output logic       loada,
   output logic       loadb,
   output logic       loadc,
   output logic       loads,
   output logic       asel,
   output logic       bsel,
   output logic       write,
   output logic       retire,
   output logic       halted,
   output logic       trap
);

   state_t r_state;
   state_t w_next;
   ctrl_t  r_ctrl;
   cls_t   w_cls;

   cpu_controller_classify u_classify (
      .i_opcode (opcode),
      .i_op     (op),
      .o_cls    (w_cls)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RST:       w_next = S_IF1;
         S_IF1:       w_next = S_IF2;
         S_IF2:       w_next = S_UPDATE_PC;
`ifdef CPU_CONTROLLER_TRAP_EN
         S_UPDATE_PC: w_next = S_DECODE;
`else
         // The IR is already loaded here, so an illegal encoding is steered
         // into a retiring decode state to keep retire a pure state output.
         S_UPDATE_PC: w_next = (w_cls == C_ILLEGAL) ? S_DECODE_NOP : S_DECODE;
`endif
         S_DECODE: begin
            case (w_cls)
               C_MOVI:                     w_next = S_WR_IMM;
               C_MOVR, C_MVN:              w_next = S_GET_B;
               C_ALU, C_CMP, C_LDR, C_STR: w_next = S_GET_A;
               C_HALT:                     w_next = S_HALT;
`ifdef CPU_CONTROLLER_TRAP_EN
               default:                    w_next = S_TRAP;
`else
               default:                    w_next = S_IF1;
`endif
            endcase
         end
         S_DECODE_NOP: w_next = S_IF1;
         S_WR_IMM:     w_next = S_IF1;
         S_GET_A:      w_next = (w_cls == C_LDR || w_cls == C_STR) ? S_ADDR_C : S_GET_B;
         S_GET_B: begin
            case (w_cls)
               C_CMP:         w_next = S_CMP_S;
               C_MOVR, C_MVN: w_next = S_ALU_C1;
               default:       w_next = S_ALU_C0;
            endcase
         end
         S_ALU_C0, S_ALU_C1: w_next = S_WR_RD;
         S_CMP_S:   w_next = S_IF1;
         S_WR_RD:   w_next = S_IF1;
         S_ADDR_C:  w_next = S_LD_ADDR;
         S_LD_ADDR: w_next = (w_cls == C_STR) ? S_GET_D : S_MEM_RD;
         S_MEM_RD:  w_next = S_MEM_WB;
         S_MEM_WB:  w_next = S_IF1;
         S_GET_D:   w_next = S_STR_C;
         S_STR_C:   w_next = S_MEM_WR;
         S_MEM_WR:  w_next = S_IF1;
         S_HALT:    w_next = S_HALT;
         S_TRAP:    w_next = S_TRAP;
         default:   w_next = S_RST;
      endcase
   end

`ifdef CPU_CONTROLLER_TRAP_EN
   logic r_trap;
`endif

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_RST;
         r_ctrl  <= ctrl_decode(S_RST);
`ifdef CPU_CONTROLLER_TRAP_EN
         r_trap  <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         r_ctrl  <= ctrl_decode(w_next);
`ifdef CPU_CONTROLLER_TRAP_EN
         r_trap  <= (w_next == S_TRAP);
`endif
      end
   end

   assign load_pc   = r_ctrl.load_pc;
   assign reset_pc  = r_ctrl.reset_pc;
   assign addr_sel  = r_ctrl.addr_sel;
   assign load_ir   = r_ctrl.load_ir;
   assign load_addr = r_ctrl.load_addr;
   assign mem_cmd   = r_ctrl.mem_cmd;
   assign nsel      = r_ctrl.nsel;
   assign vsel      = r_ctrl.vsel;
   assign loada     = r_ctrl.loada;
   assign loadb     = r_ctrl.loadb;
   assign loadc     = r_ctrl.loadc;
   assign loads     = r_ctrl.loads;
   assign asel      = r_ctrl.asel;
   assign bsel      = r_ctrl.bsel;
   assign write     = r_ctrl.write;
   assign retire    = r_ctrl.retire;
   assign halted    = r_ctrl.halted;
`ifdef CPU_CONTROLLER_TRAP_EN
   assign trap      = r_trap;
`else
   assign trap      = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: per-instruction control profiles checked at retire.
module tb_cpu_controller;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [2:0] opcode;
   logic [1:0] op;
   logic       load_pc, reset_pc, addr_sel, load_ir, load_addr;
   logic [1:0] mem_cmd;
   logic [2:0] nsel;
   logic [1:0] vsel;
   logic       loada, loadb, loadc, loads, asel, bsel, write, retire, halted, trap;

   cpu_controller dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .op(op),
      .load_pc(load_pc), .reset_pc(reset_pc), .addr_sel(addr_sel), .load_ir(load_ir),
      .load_addr(load_addr), .mem_cmd(mem_cmd), .nsel(nsel), .vsel(vsel),
      .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel),
      .bsel(bsel), .write(write), .retire(retire), .halted(halted), .trap(trap)
   );

   always #5 clk = ~clk;

   // Cycle indices are relative to IF1 (=0); 15 means the event never happened.
   typedef struct {
      int ret, la, lb, lc, ladr, mrd, nwr, nmw, nld, asel_c, vsel, nsel;
   } prof_t;

   prof_t q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic prof_t mk(int ret, int la, int lb, int lc, int ladr, int mrd,
                                int nwr, int nmw, int nld, int asel_c, int vs, int ns);
      prof_t p;
      p.ret = ret; p.la = la; p.lb = lb; p.lc = lc; p.ladr = ladr; p.mrd = mrd;
      p.nwr = nwr; p.nmw = nmw; p.nld = nld; p.asel_c = asel_c; p.vsel = vs; p.nsel = ns;
      return p;
   endfunction

   function automatic prof_t blank();
      return mk(15, 15, 15, 15, 15, 15, 0, 0, 0, 0, 0, 0);
   endfunction

   // Monitor: builds the observed profile of the running instruction and
   // compares it against the scoreboard head whenever retire is presented.
   int    idx = 0;
   prof_t obs;
   initial obs = blank();

   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (addr_sel && mem_cmd == 2'b01 && !load_ir) begin
            idx = 0;
            obs = blank();
         end else begin
            idx++;
         end
         if (loada && obs.la == 15) obs.la = idx;
         if (loadb && obs.lb == 15) obs.lb = idx;
         if (loadc && obs.lc == 15) begin obs.lc = idx; obs.asel_c = int'(asel); end
         if (load_addr && obs.ladr == 15) obs.ladr = idx;
         if (mem_cmd == 2'b01 && !addr_sel && obs.mrd == 15) obs.mrd = idx;
         if (write) obs.nwr++;
         if (mem_cmd == 2'b10) obs.nmw++;
         if (loads) obs.nld++;
         if (retire) begin
            obs.ret = idx; obs.vsel = int'(vsel); obs.nsel = int'(nsel);
            if (q.size() == 0) begin
               chk("retire_with_empty_scoreboard", q.size(), 1);
            end else begin
               prof_t e;
               e = q.pop_front();
               chk("retire_idx", obs.ret, e.ret);
               chk("loada_idx", obs.la, e.la);
               chk("loadb_idx", obs.lb, e.lb);
               chk("loadc_idx", obs.lc, e.lc);
               chk("load_addr_idx", obs.ladr, e.ladr);
               chk("mem_read_data_idx", obs.mrd, e.mrd);
               chk("write_pulses", obs.nwr, e.nwr);
               chk("mem_write_cycles", obs.nmw, e.nmw);
               chk("loads_pulses", obs.nld, e.nld);
               chk("asel_at_loadc", obs.asel_c, e.asel_c);
               chk("vsel_at_retire", obs.vsel, e.vsel);
               chk("nsel_at_retire", obs.nsel, e.nsel);
            end
         end
      end
   end

   task automatic issue(input logic [2:0] opc, input logic [1:0] o);
      opcode = opc;
      op     = o;
   endtask

   task automatic wait_retire(input string name);
      int seen;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (retire) begin seen = 1; break; end
      end
      if (seen == 0) chk(name, seen, 1);
   endtask

   task automatic run(input logic [2:0] opc, input logic [1:0] o, input prof_t p, input string name);
      issue(opc, o);
      q.push_back(p);
      wait_retire(name);
   endtask

   initial begin
      int cnt, rcnt, seen;
      reset_n = 1'b0;
      issue(3'b000, 2'b00);
      repeat (10) @(negedge clk);
      chk("rst_reset_pc", reset_pc, 1);
      chk("rst_load_pc", load_pc, 1);
      chk("rst_addr_sel", addr_sel, 0);
      chk("rst_mem_cmd", mem_cmd, 0);
      chk("rst_write", write, 0);
      chk("rst_retire", retire, 0);

      // MOV R0,#7: fetch shape is checked directly, profile by the monitor
      issue(3'b110, 2'b10);
      q.push_back(mk(4, 15, 15, 15, 15, 15, 1, 0, 0, 0, 2, 1));
      reset_n = 1'b1;
      @(negedge clk);
      chk("if1_addr_sel", addr_sel, 1);
      chk("if1_mem_cmd", mem_cmd, 1);
      chk("if1_load_ir", load_ir, 0);
      chk("if1_reset_pc", reset_pc, 0);
      @(negedge clk);
      chk("if2_addr_sel", addr_sel, 1);
      chk("if2_mem_cmd", mem_cmd, 1);
      chk("if2_load_ir", load_ir, 1);
      wait_retire("movi_timeout");

      run(3'b101, 2'b00, mk(7, 4, 5, 6, 15, 15, 1, 0, 0, 0, 0, 2), "add_timeout");
      run(3'b101, 2'b10, mk(7, 4, 5, 6, 15, 15, 1, 0, 0, 0, 0, 2), "and_timeout");
      run(3'b101, 2'b01, mk(6, 4, 5, 15, 15, 15, 0, 0, 1, 0, 0, 0), "cmp_timeout");
      run(3'b110, 2'b00, mk(6, 15, 4, 5, 15, 15, 1, 0, 0, 1, 0, 2), "movr_timeout");
      run(3'b101, 2'b11, mk(6, 15, 4, 5, 15, 15, 1, 0, 0, 1, 0, 2), "mvn_timeout");
      run(3'b011, 2'b00, mk(8, 4, 15, 5, 6, 7, 1, 0, 0, 0, 3, 2), "ldr_timeout");
      run(3'b100, 2'b00, mk(9, 4, 7, 5, 6, 15, 0, 1, 0, 0, 0, 0), "str_timeout");

      // ADD aborted in GET_B by an asynchronous reset; it is then refetched
      issue(3'b101, 2'b00);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (loadb) begin seen = 1; break; end
      end
      chk("abort_reached_get_b", seen, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("abort_async_reset_pc", reset_pc, 1);
      chk("abort_async_loadb", loadb, 0);
      cnt = 0;
      repeat (2) begin
         @(negedge clk);
         if (write || retire) cnt++;
      end
      chk("abort_no_write_retire", cnt, 0);
      q.push_back(mk(7, 4, 5, 6, 15, 15, 1, 0, 0, 0, 0, 2));
      reset_n = 1'b1;
      wait_retire("add_after_abort_timeout");

      // HALT holds with no retire pulses
      issue(3'b111, 2'b00);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (halted) begin seen = 1; break; end
      end
      chk("halt_entered", seen, 1);
      cnt = 0; rcnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (halted) cnt++;
         if (retire) rcnt++;
      end
      chk("halt_cycles", cnt, 20);
      chk("halt_retires", rcnt, 0);
      reset_n = 1'b0;
      issue(3'b000, 2'b00);
      @(negedge clk);
      chk("halt_cleared_by_reset", halted, 0);
      @(negedge clk);
      reset_n = 1'b1;

`ifdef CPU_CONTROLLER_TRAP_EN
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (trap) begin seen = 1; break; end
      end
      chk("trap_entered", seen, 1);
      repeat (10) @(negedge clk);
      chk("trap_latched", trap, 1);
      chk("trap_halted", halted, 1);
      reset_n = 1'b0;
      @(negedge clk);
      chk("trap_cleared_by_reset", trap, 0);
      reset_n = 1'b1;
      run(3'b110, 2'b10, mk(4, 15, 15, 15, 15, 15, 1, 0, 0, 0, 2, 1), "movi_after_trap_timeout");
`else
      q.push_back(mk(3, 15, 15, 15, 15, 15, 0, 0, 0, 0, 0, 0));
      wait_retire("nop_timeout");
      chk("nop_trap_low", trap, 0);
      run(3'b110, 2'b10, mk(4, 15, 15, 15, 15, 15, 1, 0, 0, 0, 2, 1), "movi_after_nop_timeout");
`endif

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
